// File: rtl/tank_mover_pkg.sv
// Shared direction codes, playfield defaults and FSM state type for the tank mover
// and the direction encoder that feeds it.
package tank_mover_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam int         DIR_VALID_BIT = 2;

    localparam int X_MAX_DEFAULT = 159;
    localparam int Y_MAX_DEFAULT = 119;

    typedef enum logic {
        IDLE,
        MOVING
    } tank_state_e;

endpackage

// File: rtl/tank_mover_step_timer.sv
// step_timer: free-running step divider; tick marks the last cycle of each STEP_DIV interval.
module step_timer #(
    parameter int STEP_DIV = 833333
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int WIDTH = $clog2(STEP_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == WIDTH'(STEP_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tank_mover.sv
// Tank position/facing FSM: steps every STEP_DIV cycles while a direction is held.
// Define TANK_MOVER_WRAP_EN to wrap at the playfield edges instead of clamping.
module tank_mover
    import tank_mover_pkg::*;
#(
    parameter int X_MAX    = X_MAX_DEFAULT,
    parameter int Y_MAX    = Y_MAX_DEFAULT,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60,
    parameter int STEP     = 1,
    parameter int STEP_DIV = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] direction,
    input  logic       blocked,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [1:0] facing,
    output logic       moving,
    output logic       step_pulse
);

    tank_state_e state_q, state_d;
    logic [7:0]  x_q, x_d, stepX;
    logic [6:0]  y_q, y_d, stepY;
    logic [1:0]  facing_q, facing_d;
    logic        pulse_q, pulse_d;
    logic        timerClear, timerEnable, timerTick;
    logic        dirValid;

    // Bounds are tested before the add/subtract so an unsigned coordinate never underflows.
    function automatic int nextCoord(input int pos, input int maxVal, input logic inc);
        int res;
        if (inc) begin
`ifdef TANK_MOVER_WRAP_EN
            res = (pos > maxVal - STEP) ? pos + STEP - maxVal - 1 : pos + STEP;
`else
            res = (pos > maxVal - STEP) ? maxVal : pos + STEP;
`endif
        end else begin
`ifdef TANK_MOVER_WRAP_EN
            res = (pos < STEP) ? pos + maxVal + 1 - STEP : pos - STEP;
`else
            res = (pos < STEP) ? 0 : pos - STEP;
`endif
        end
        return res;
    endfunction

    step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clk    (clk),
        .clear  (reset | timerClear),
        .enable (timerEnable),
        .tick   (timerTick)
    );

    assign dirValid = direction[DIR_VALID_BIT];

    always_comb begin
        stepX = x_q;
        stepY = y_q;
        case (facing_q)
            DIR_UP:    stepY = 7'(nextCoord(int'(y_q), Y_MAX, 1'b0));
            DIR_DOWN:  stepY = 7'(nextCoord(int'(y_q), Y_MAX, 1'b1));
            DIR_LEFT:  stepX = 8'(nextCoord(int'(x_q), X_MAX, 1'b0));
            default:   stepX = 8'(nextCoord(int'(x_q), X_MAX, 1'b1));
        endcase
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        facing_d    = facing_q;
        pulse_d     = 1'b0;
        timerClear  = 1'b0;
        timerEnable = 1'b0;
        case (state_q)
            IDLE: begin
                timerClear = 1'b1;
                if (dirValid) begin
                    state_d  = MOVING;
                    facing_d = direction[1:0];
                end
            end
            MOVING: begin
                if (!dirValid) begin
                    state_d    = IDLE;
                    timerClear = 1'b1;
                end else if (direction[1:0] != facing_q) begin
                    facing_d   = direction[1:0];
                    timerClear = 1'b1;
                end else begin
                    timerEnable = 1'b1;
                    if (timerTick && !blocked) begin
                        x_d = stepX;
                        y_d = stepY;
`ifdef TANK_MOVER_WRAP_EN
                        pulse_d = 1'b1;
`else
                        pulse_d = (stepX != x_q) || (stepY != y_q);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= 8'(X_INIT);
            y_q      <= 7'(Y_INIT);
            facing_q <= DIR_UP;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
            pulse_q  <= pulse_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign facing     = facing_q;
    assign moving     = (state_q == MOVING);
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_tank_mover.sv
// Directed self-checking bench for tank_mover with STEP_DIV=4; honours TANK_MOVER_WRAP_EN.
module tb_tank_mover;

    logic       clk;
    logic       reset;
    logic [2:0] direction;
    logic       blocked;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] facing;
    logic       moving;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;
    int pulseCount;

    tank_mover #(.STEP_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .direction  (direction),
        .blocked    (blocked),
        .x          (x),
        .y          (y),
        .facing     (facing),
        .moving     (moving),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs and let the given number of rising edges go by, ending on a falling edge.
    task automatic applyStimulus(input logic [2:0] dir, input logic blk, input int cycles);
        direction = dir;
        blocked   = blk;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b1;
        direction = 3'b000;
        blocked   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_x", 32'(x), 80);
        checkOutput("reset_y", 32'(y), 60);
        checkOutput("reset_facing", 32'(facing), 0);
        checkOutput("reset_moving", 32'(moving), 0);
        checkOutput("reset_pulse", 32'(step_pulse), 0);

        // Hold up for 12 cycles past E0: steps at E0+4, +8, +12.
        direction  = 3'b100;
        pulseCount = 0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            pulseCount += int'(step_pulse);
            if (i == 1) begin
                checkOutput("up_moving", 32'(moving), 1);
                checkOutput("up_facing", 32'(facing), 0);
            end
            if (i == 4) checkOutput("up_y_before_step", 32'(y), 60);
            if (i == 5) begin
                checkOutput("up_y_first_step", 32'(y), 59);
                checkOutput("up_pulse_first_step", 32'(step_pulse), 1);
            end
        end
        checkOutput("up_y_final", 32'(y), 57);
        checkOutput("up_x_final", 32'(x), 80);
        checkOutput("up_pulse_count", 32'(pulseCount), 3);

        applyStimulus(3'b000, 1'b0, 1);
        checkOutput("release_moving", 32'(moving), 0);
        checkOutput("release_y", 32'(y), 57);

        // Release lands exactly on the would-be step edge.
        applyStimulus(3'b100, 1'b0, 4);
        applyStimulus(3'b000, 1'b0, 1);
        checkOutput("edge_release_y", 32'(y), 57);
        checkOutput("edge_release_moving", 32'(moving), 0);
        checkOutput("edge_release_pulse", 32'(step_pulse), 0);
        applyStimulus(3'b100, 1'b0, 4);
        checkOutput("repress_y_wait", 32'(y), 57);
        applyStimulus(3'b100, 1'b0, 1);
        checkOutput("repress_y_step", 32'(y), 56);
        checkOutput("repress_pulse", 32'(step_pulse), 1);

        // Direction change restarts the interval.
        applyStimulus(3'b101, 1'b0, 3);
        applyStimulus(3'b110, 1'b0, 1);
        checkOutput("turn_facing", 32'(facing), 2);
        checkOutput("turn_y", 32'(y), 56);
        checkOutput("turn_x", 32'(x), 80);
        checkOutput("turn_pulse", 32'(step_pulse), 0);
        applyStimulus(3'b110, 1'b0, 3);
        checkOutput("turn_x_wait", 32'(x), 80);
        applyStimulus(3'b110, 1'b0, 1);
        checkOutput("turn_x_step", 32'(x), 79);
        checkOutput("turn_pulse_step", 32'(step_pulse), 1);

        // Blocked on every step edge.
        direction  = 3'b110;
        blocked    = 1'b1;
        pulseCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulseCount += int'(step_pulse);
        end
        blocked = 1'b0;
        checkOutput("blocked_x", 32'(x), 79);
        checkOutput("blocked_pulses", 32'(pulseCount), 0);
        checkOutput("blocked_moving", 32'(moving), 1);
        checkOutput("blocked_facing", 32'(facing), 2);

        // Reset in the middle of a move.
        applyStimulus(3'b100, 1'b0, 3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_x", 32'(x), 80);
        checkOutput("midreset_y", 32'(y), 60);
        checkOutput("midreset_facing", 32'(facing), 0);
        checkOutput("midreset_moving", 32'(moving), 0);
        checkOutput("midreset_pulse", 32'(step_pulse), 0);
        reset = 1'b0;
        applyStimulus(3'b100, 1'b0, 1);
        checkOutput("postreset_moving", 32'(moving), 1);
        applyStimulus(3'b100, 1'b0, 3);
        checkOutput("postreset_y_wait", 32'(y), 60);
        applyStimulus(3'b100, 1'b0, 1);
        checkOutput("postreset_y_step", 32'(y), 59);

        // Drive right across the playfield to the right edge.
        applyStimulus(3'b111, 1'b0, 1);
        checkOutput("right_facing", 32'(facing), 3);
        checkOutput("right_x_start", 32'(x), 80);
        applyStimulus(3'b111, 1'b0, 312);
        checkOutput("right_x_158", 32'(x), 158);
        applyStimulus(3'b111, 1'b0, 4);
        checkOutput("right_x_159", 32'(x), 159);
        checkOutput("right_pulse_159", 32'(step_pulse), 1);
        pulseCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulseCount += int'(step_pulse);
        end
`ifdef TANK_MOVER_WRAP_EN
        checkOutput("edge_x_after", 32'(x), 1);
        checkOutput("edge_pulses", 32'(pulseCount), 2);
`else
        checkOutput("edge_x_after", 32'(x), 159);
        checkOutput("edge_pulses", 32'(pulseCount), 0);
`endif
        checkOutput("edge_y", 32'(y), 59);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
